// File: rtl/clint_bus_pkg.sv
// Shared types and constants for the CLINT AXI4-Lite arbiter slice.
package clint_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } chan_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the master not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // last = 1 means master 1 was served most recently
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/clint_axil_arbiter.sv
// Two-master AXI4-Lite arbiter in front of the CLINT; read and write channels
// are arbitrated independently with one outstanding transaction each.
module clint_axil_arbiter
    import clint_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   m0_axi_araddr,
    input  logic [2:0]          m0_axi_arprot,
    input  logic                m0_axi_arvalid,
    output logic                m0_axi_arready,
    output logic [DATA_W-1:0]   m0_axi_rdata,
    output logic [1:0]          m0_axi_rresp,
    output logic                m0_axi_rvalid,
    input  logic                m0_axi_rready,
    input  logic [ADDR_W-1:0]   m0_axi_awaddr,
    input  logic [2:0]          m0_axi_awprot,
    input  logic                m0_axi_awvalid,
    output logic                m0_axi_awready,
    input  logic [DATA_W-1:0]   m0_axi_wdata,
    input  logic [DATA_W/8-1:0] m0_axi_wstrb,
    input  logic                m0_axi_wvalid,
    output logic                m0_axi_wready,
    output logic [1:0]          m0_axi_bresp,
    output logic                m0_axi_bvalid,
    input  logic                m0_axi_bready,

    input  logic [ADDR_W-1:0]   m1_axi_araddr,
    input  logic [2:0]          m1_axi_arprot,
    input  logic                m1_axi_arvalid,
    output logic                m1_axi_arready,
    output logic [DATA_W-1:0]   m1_axi_rdata,
    output logic [1:0]          m1_axi_rresp,
    output logic                m1_axi_rvalid,
    input  logic                m1_axi_rready,
    input  logic [ADDR_W-1:0]   m1_axi_awaddr,
    input  logic [2:0]          m1_axi_awprot,
    input  logic                m1_axi_awvalid,
    output logic                m1_axi_awready,
    input  logic [DATA_W-1:0]   m1_axi_wdata,
    input  logic [DATA_W/8-1:0] m1_axi_wstrb,
    input  logic                m1_axi_wvalid,
    output logic                m1_axi_wready,
    output logic [1:0]          m1_axi_bresp,
    output logic                m1_axi_bvalid,
    input  logic                m1_axi_bready,

    output logic [ADDR_W-1:0]   s_axi_araddr,
    output logic [2:0]          s_axi_arprot,
    output logic                s_axi_arvalid,
    input  logic                s_axi_arready,
    input  logic [DATA_W-1:0]   s_axi_rdata,
    input  logic [1:0]          s_axi_rresp,
    input  logic                s_axi_rvalid,
    output logic                s_axi_rready,
    output logic [ADDR_W-1:0]   s_axi_awaddr,
    output logic [2:0]          s_axi_awprot,
    output logic                s_axi_awvalid,
    input  logic                s_axi_awready,
    output logic [DATA_W-1:0]   s_axi_wdata,
    output logic [DATA_W/8-1:0] s_axi_wstrb,
    output logic                s_axi_wvalid,
    input  logic                s_axi_wready,
    input  logic [1:0]          s_axi_bresp,
    input  logic                s_axi_bvalid,
    output logic                s_axi_bready
);

    chan_state_t       rd_state_r;
    logic              rd_owner_r;
    logic              rd_last_r;
    logic [DATA_W-1:0] rd_data_r;
    logic [1:0]        rd_resp_r;
    logic [1:0]        rd_req_s;
    logic [1:0]        rd_grant_s;
    logic              rd_hs_s;
    logic              rd_owner_ready_s;

    chan_state_t       wr_state_r;
    logic              wr_owner_r;
    logic              wr_last_r;
    logic [1:0]        wr_resp_r;
    logic [1:0]        wr_req_s;
    logic [1:0]        wr_grant_s;
    logic              wr_hs_s;
    logic              wr_owner_ready_s;
    logic              aw_ok_s;
    logic              w_ok_s;

    assign rd_req_s = {m1_axi_arvalid, m0_axi_arvalid};
    // A write request needs AW and W together: the CLINT only acts on both at once
    assign wr_req_s = {m1_axi_awvalid & m1_axi_wvalid, m0_axi_awvalid & m0_axi_wvalid};

    rr_arb2 u_rd_arb (
        .req   (rd_req_s),
        .last  (rd_last_r),
        .grant (rd_grant_s)
    );

    rr_arb2 u_wr_arb (
        .req   (wr_req_s),
        .last  (wr_last_r),
        .grant (wr_grant_s)
    );

    assign m0_axi_arready = (rd_state_r == IDLE) & rd_grant_s[0];
    assign m1_axi_arready = (rd_state_r == IDLE) & rd_grant_s[1];
    assign m0_axi_awready = (wr_state_r == IDLE) & wr_grant_s[0];
    assign m1_axi_awready = (wr_state_r == IDLE) & wr_grant_s[1];
    assign m0_axi_wready  = m0_axi_awready;
    assign m1_axi_wready  = m1_axi_awready;

    assign rd_hs_s = (m0_axi_arvalid & m0_axi_arready) | (m1_axi_arvalid & m1_axi_arready);
    assign wr_hs_s = (m0_axi_awvalid & m0_axi_awready) | (m1_axi_awvalid & m1_axi_awready);

    assign rd_owner_ready_s = rd_owner_r ? m1_axi_rready : m0_axi_rready;
    assign wr_owner_ready_s = wr_owner_r ? m1_axi_bready : m0_axi_bready;

    // AW and W each count as accepted once their own ready has been seen
    assign aw_ok_s = ~s_axi_awvalid | s_axi_awready;
    assign w_ok_s  = ~s_axi_wvalid | s_axi_wready;

    assign m0_axi_rdata = rd_data_r;
    assign m1_axi_rdata = rd_data_r;
    assign m0_axi_rresp = rd_resp_r;
    assign m1_axi_rresp = rd_resp_r;
    assign m0_axi_bresp = wr_resp_r;
    assign m1_axi_bresp = wr_resp_r;

    // Read channel FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r    <= IDLE;
            rd_owner_r    <= 1'b0;
            rd_last_r     <= 1'b1;
            rd_data_r     <= '0;
            rd_resp_r     <= RESP_OKAY;
            s_axi_araddr  <= '0;
            s_axi_arprot  <= 3'b000;
            s_axi_arvalid <= 1'b0;
            s_axi_rready  <= 1'b0;
            m0_axi_rvalid <= 1'b0;
            m1_axi_rvalid <= 1'b0;
        end else begin
            case (rd_state_r)
                IDLE: begin
                    if (rd_hs_s) begin
                        rd_owner_r    <= rd_grant_s[1];
                        s_axi_araddr  <= rd_grant_s[1] ? m1_axi_araddr : m0_axi_araddr;
                        s_axi_arprot  <= rd_grant_s[1] ? m1_axi_arprot : m0_axi_arprot;
                        s_axi_arvalid <= 1'b1;
                        rd_state_r    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_axi_arready) begin
                        s_axi_arvalid <= 1'b0;
                        s_axi_rready  <= 1'b1;
                        rd_state_r    <= RESP;
                    end
                end
                RESP: begin
                    if (s_axi_rvalid) begin
                        s_axi_rready  <= 1'b0;
                        rd_data_r     <= s_axi_rdata;
                        rd_resp_r     <= s_axi_rresp;
                        m0_axi_rvalid <= ~rd_owner_r;
                        m1_axi_rvalid <= rd_owner_r;
                        rd_state_r    <= DONE;
                    end
                end
                DONE: begin
                    if (rd_owner_ready_s) begin
                        m0_axi_rvalid <= 1'b0;
                        m1_axi_rvalid <= 1'b0;
                        rd_last_r     <= rd_owner_r;
                        rd_state_r    <= IDLE;
                    end
                end
                default: rd_state_r <= IDLE;
            endcase
        end
    end

    // Write channel FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r    <= IDLE;
            wr_owner_r    <= 1'b0;
            wr_last_r     <= 1'b1;
            wr_resp_r     <= RESP_OKAY;
            s_axi_awaddr  <= '0;
            s_axi_awprot  <= 3'b000;
            s_axi_awvalid <= 1'b0;
            s_axi_wdata   <= '0;
            s_axi_wstrb   <= '0;
            s_axi_wvalid  <= 1'b0;
            s_axi_bready  <= 1'b0;
            m0_axi_bvalid <= 1'b0;
            m1_axi_bvalid <= 1'b0;
        end else begin
            case (wr_state_r)
                IDLE: begin
                    if (wr_hs_s) begin
                        wr_owner_r    <= wr_grant_s[1];
                        s_axi_awaddr  <= wr_grant_s[1] ? m1_axi_awaddr : m0_axi_awaddr;
                        s_axi_awprot  <= wr_grant_s[1] ? m1_axi_awprot : m0_axi_awprot;
                        s_axi_wdata   <= wr_grant_s[1] ? m1_axi_wdata  : m0_axi_wdata;
                        s_axi_wstrb   <= wr_grant_s[1] ? m1_axi_wstrb  : m0_axi_wstrb;
                        s_axi_awvalid <= 1'b1;
                        s_axi_wvalid  <= 1'b1;
                        wr_state_r    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_axi_awready) begin
                        s_axi_awvalid <= 1'b0;
                    end
                    if (s_axi_wready) begin
                        s_axi_wvalid <= 1'b0;
                    end
                    if (aw_ok_s && w_ok_s) begin
                        s_axi_bready <= 1'b1;
                        wr_state_r   <= RESP;
                    end
                end
                RESP: begin
                    if (s_axi_bvalid) begin
                        s_axi_bready  <= 1'b0;
                        wr_resp_r     <= s_axi_bresp;
                        m0_axi_bvalid <= ~wr_owner_r;
                        m1_axi_bvalid <= wr_owner_r;
                        wr_state_r    <= DONE;
                    end
                end
                DONE: begin
                    if (wr_owner_ready_s) begin
                        m0_axi_bvalid <= 1'b0;
                        m1_axi_bvalid <= 1'b0;
                        wr_last_r     <= wr_owner_r;
                        wr_state_r    <= IDLE;
                    end
                end
                default: wr_state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_axil_arbiter.sv
// Bench for clint_axil_arbiter: directed and random transactions against a CLINT
// stand-in, checked against a register-map model and the documented latencies.
module tb_clint_axil_arbiter;
    import clint_bus_pkg::*;

    localparam int BUDGET = 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] m0_axi_araddr, m1_axi_araddr, m0_axi_awaddr, m1_axi_awaddr;
    logic [2:0]  m0_axi_arprot, m1_axi_arprot, m0_axi_awprot, m1_axi_awprot;
    logic        m0_axi_arvalid, m1_axi_arvalid, m0_axi_arready, m1_axi_arready;
    logic [31:0] m0_axi_rdata, m1_axi_rdata;
    logic [1:0]  m0_axi_rresp, m1_axi_rresp, m0_axi_bresp, m1_axi_bresp;
    logic        m0_axi_rvalid, m1_axi_rvalid, m0_axi_rready, m1_axi_rready;
    logic        m0_axi_awvalid, m1_axi_awvalid, m0_axi_awready, m1_axi_awready;
    logic [31:0] m0_axi_wdata, m1_axi_wdata;
    logic [3:0]  m0_axi_wstrb, m1_axi_wstrb;
    logic        m0_axi_wvalid, m1_axi_wvalid, m0_axi_wready, m1_axi_wready;
    logic        m0_axi_bvalid, m1_axi_bvalid, m0_axi_bready, m1_axi_bready;

    logic [31:0] s_axi_araddr, s_axi_rdata, s_axi_awaddr, s_axi_wdata;
    logic [2:0]  s_axi_arprot, s_axi_awprot;
    logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
    logic [1:0]  s_axi_rresp, s_axi_bresp;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;

    clint_axil_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot), .m0_axi_arvalid(m0_axi_arvalid),
        .m0_axi_arready(m0_axi_arready), .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp),
        .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready), .m0_axi_awaddr(m0_axi_awaddr),
        .m0_axi_awprot(m0_axi_awprot), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready),
        .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wvalid(m0_axi_wvalid),
        .m0_axi_wready(m0_axi_wready), .m0_axi_bresp(m0_axi_bresp), .m0_axi_bvalid(m0_axi_bvalid),
        .m0_axi_bready(m0_axi_bready),
        .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot), .m1_axi_arvalid(m1_axi_arvalid),
        .m1_axi_arready(m1_axi_arready), .m1_axi_rdata(m1_axi_rdata), .m1_axi_rresp(m1_axi_rresp),
        .m1_axi_rvalid(m1_axi_rvalid), .m1_axi_rready(m1_axi_rready), .m1_axi_awaddr(m1_axi_awaddr),
        .m1_axi_awprot(m1_axi_awprot), .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready),
        .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_wvalid(m1_axi_wvalid),
        .m1_axi_wready(m1_axi_wready), .m1_axi_bresp(m1_axi_bresp), .m1_axi_bvalid(m1_axi_bvalid),
        .m1_axi_bready(m1_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_mapped(input logic [31:0] a);
        return (a == 32'h0) || (a == 32'h4000) || (a == 32'h4004) || (a == 32'hbff8) || (a == 32'hbffc);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // CLINT stand-in: always ready, one-cycle registered response, mtime counts every cycle
    logic [63:0] mtime;
    logic        slv_msip;
    logic [31:0] slv_lo, slv_hi;
    assign s_axi_arready = 1'b1;
    assign s_axi_awready = 1'b1;
    assign s_axi_wready  = 1'b1;

    function automatic logic [33:0] slv_read(input logic [31:0] a);
        case (a)
            32'h0:    return {2'b00, 31'd0, slv_msip};
            32'h4000: return {2'b00, slv_lo};
            32'h4004: return {2'b00, slv_hi};
            32'hbff8: return {2'b00, mtime[31:0]};
            32'hbffc: return {2'b00, mtime[63:32]};
            default:  return {RESP_SLVERR, 32'd0};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mtime <= 64'd0; slv_msip <= 1'b0; slv_lo <= 32'd0; slv_hi <= 32'd0;
            s_axi_rvalid <= 1'b0; s_axi_rdata <= 32'd0; s_axi_rresp <= 2'b00;
            s_axi_bvalid <= 1'b0; s_axi_bresp <= 2'b00;
        end else begin
            mtime <= mtime + 64'd1;
            if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
            if (s_axi_arvalid) begin
                s_axi_rvalid <= 1'b1;
                {s_axi_rresp, s_axi_rdata} <= slv_read(s_axi_araddr);
            end
            if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
            if (s_axi_awvalid && s_axi_wvalid) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= is_mapped(s_axi_awaddr) ? RESP_OKAY : RESP_SLVERR;
                if (s_axi_awaddr == 32'h0 && s_axi_wstrb[0]) slv_msip <= s_axi_wdata[0];
                if (s_axi_awaddr == 32'h4000) slv_lo <= merge(slv_lo, s_axi_wdata, s_axi_wstrb);
                if (s_axi_awaddr == 32'h4004) slv_hi <= merge(slv_hi, s_axi_wdata, s_axi_wstrb);
            end
        end
    end

    // Reference register map as the masters expect to see it
    logic        mdl_msip;
    logic [31:0] mdl_lo, mdl_hi;

    task automatic model_reset();
        mdl_msip = 1'b0; mdl_lo = 32'd0; mdl_hi = 32'd0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a == 32'h0 && s[0]) mdl_msip = d[0];
        if (a == 32'h4000) mdl_lo = merge(mdl_lo, d, s);
        if (a == 32'h4004) mdl_hi = merge(mdl_hi, d, s);
    endtask

    // t0 is mtime in the master handshake cycle; the CLINT samples it one cycle later
    function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [63:0] t0);
        logic [63:0] t1;
        t1 = t0 + 64'd1;
        case (a)
            32'h0:    return {31'd0, mdl_msip};
            32'h4000: return mdl_lo;
            32'h4004: return mdl_hi;
            32'hbff8: return t1[31:0];
            32'hbffc: return t1[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] prot_of(input int m);
        return (m == 1) ? 3'b101 : 3'b010;
    endfunction
    function automatic logic arready_of(input int m); return (m == 1) ? m1_axi_arready : m0_axi_arready; endfunction
    function automatic logic rvalid_of(input int m);  return (m == 1) ? m1_axi_rvalid  : m0_axi_rvalid;  endfunction
    function automatic logic [33:0] r_of(input int m);
        return (m == 1) ? {m1_axi_rresp, m1_axi_rdata} : {m0_axi_rresp, m0_axi_rdata};
    endfunction
    function automatic logic [1:0] aw_w_ready_of(input int m);
        return (m == 1) ? {m1_axi_awready, m1_axi_wready} : {m0_axi_awready, m0_axi_wready};
    endfunction
    function automatic logic bvalid_of(input int m);  return (m == 1) ? m1_axi_bvalid : m0_axi_bvalid; endfunction
    function automatic logic [1:0] bresp_of(input int m); return (m == 1) ? m1_axi_bresp : m0_axi_bresp; endfunction

    task automatic set_ar(input int m, input logic [31:0] a, input logic v);
        if (m == 1) begin m1_axi_araddr = a; m1_axi_arprot = prot_of(m); m1_axi_arvalid = v; end
        else        begin m0_axi_araddr = a; m0_axi_arprot = prot_of(m); m0_axi_arvalid = v; end
    endtask
    task automatic set_rready(input int m, input logic v);
        if (m == 1) m1_axi_rready = v; else m0_axi_rready = v;
    endtask
    task automatic set_aw(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic v);
        if (m == 1) begin
            m1_axi_awaddr = a; m1_axi_awprot = prot_of(m); m1_axi_wdata = d; m1_axi_wstrb = s;
            m1_axi_awvalid = v; m1_axi_wvalid = v;
        end else begin
            m0_axi_awaddr = a; m0_axi_awprot = prot_of(m); m0_axi_wdata = d; m0_axi_wstrb = s;
            m0_axi_awvalid = v; m0_axi_wvalid = v;
        end
    endtask
    task automatic set_bready(input int m, input logic v);
        if (m == 1) m1_axi_bready = v; else m0_axi_bready = v;
    endtask

    // Full read from master m; entered and left one time unit after a rising edge
    task automatic do_read(input int m, input logic [31:0] a, input int hold, output int hs, output int waits);
        int n;
        logic [63:0] t0;
        logic [31:0] ed;
        logic [1:0]  er;
        set_ar(m, a, 1'b1);
        #1;
        n = 0;
        while (arready_of(m) !== 1'b1 && n < BUDGET) begin @(posedge clk); #2; n++; end
        chk("ar_grant", 64'(n < BUDGET), 64'd1);
        waits = n; hs = cyc; t0 = mtime;
        @(posedge clk); #1;
        set_ar(m, a, 1'b0);
        chk("s_arvalid_c1", 64'(s_axi_arvalid), 64'd1);
        chk("s_araddr_c1", 64'(s_axi_araddr), 64'(a));
        chk("s_arprot_c1", 64'(s_axi_arprot), 64'(prot_of(m)));
        ed = exp_rdata(a, t0);
        er = is_mapped(a) ? RESP_OKAY : RESP_SLVERR;
        n = 0;
        while (rvalid_of(m) !== 1'b1 && n < BUDGET) begin @(posedge clk); #1; n++; end
        chk("r_latency", 64'(cyc - hs), 64'd3);
        chk("r_payload", 64'(r_of(m)), 64'({er, ed}));
        chk("r_other_valid", 64'(rvalid_of(1 - m)), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("r_hold_valid", 64'(rvalid_of(m)), 64'd1);
            chk("r_hold_payload", 64'(r_of(m)), 64'({er, ed}));
        end
        set_rready(m, 1'b1);
        @(posedge clk); #1;
        set_rready(m, 1'b0);
        chk("r_release", 64'(rvalid_of(m)), 64'd0);
    endtask

    // Full write from master m with AW and W presented together
    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, output int hs, output int waits);
        int n;
        logic [1:0] er;
        set_aw(m, a, d, s, 1'b1);
        #1;
        n = 0;
        while (aw_w_ready_of(m) !== 2'b11 && n < BUDGET) begin @(posedge clk); #2; n++; end
        chk("aw_grant", 64'(n < BUDGET), 64'd1);
        waits = n; hs = cyc;
        @(posedge clk); #1;
        set_aw(m, a, d, s, 1'b0);
        model_write(a, d, s);
        chk("s_aw_w_valid_c1", 64'({s_axi_awvalid, s_axi_wvalid}), 64'd3);
        chk("s_aw_payload_c1", {s_axi_awaddr, s_axi_wdata}, {a, d});
        chk("s_aw_side_c1", 64'({s_axi_awprot, s_axi_wstrb}), 64'({prot_of(m), s}));
        er = is_mapped(a) ? RESP_OKAY : RESP_SLVERR;
        n = 0;
        while (bvalid_of(m) !== 1'b1 && n < BUDGET) begin @(posedge clk); #1; n++; end
        chk("b_latency", 64'(cyc - hs), 64'd3);
        chk("b_resp", 64'(bresp_of(m)), 64'(er));
        chk("b_other_valid", 64'(bvalid_of(1 - m)), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("b_hold_valid", 64'(bvalid_of(m)), 64'd1);
        end
        set_bready(m, 1'b1);
        @(posedge clk); #1;
        set_bready(m, 1'b0);
        chk("b_release", 64'(bvalid_of(m)), 64'd0);
    endtask

    logic [31:0] addrs [7] = '{32'h0, 32'h4000, 32'h4004, 32'hbff8, 32'hbffc, 32'h1234, 32'h8};
    int hs0, hs1, w0, w1, rm, rhold, rsel;
    logic [31:0] ra, rd;
    logic [3:0]  rs;

    initial begin
        rst = 1'b1;
        set_ar(0, 32'd0, 1'b0); set_ar(1, 32'd0, 1'b0);
        set_aw(0, 32'd0, 32'd0, 4'd0, 1'b0); set_aw(1, 32'd0, 32'd0, 4'd0, 1'b0);
        set_rready(0, 1'b0); set_rready(1, 1'b0); set_bready(0, 1'b0); set_bready(1, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_valids", 64'({s_axi_arvalid, s_axi_awvalid, s_axi_wvalid}), 64'd0);
        chk("rst_s_readies", 64'({s_axi_rready, s_axi_bready}), 64'd0);
        chk("rst_m_valids", 64'({m0_axi_rvalid, m1_axi_rvalid, m0_axi_bvalid, m1_axi_bvalid}), 64'd0);
        chk("rst_payload", 64'({m0_axi_rresp, m0_axi_rdata, m0_axi_bresp}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie from reset: master 0 first, master 1 right after m0's R handshake
        fork
            do_read(0, 32'h4000, 0, hs0, w0);
            do_read(1, 32'h4004, 0, hs1, w1);
        join
        chk("tie1_m0_first", 64'(w0), 64'd0);
        chk("tie1_m1_after", 64'(hs1), 64'(hs0 + 4));
        // Next tie goes back to master 0
        fork
            do_read(0, 32'h0, 0, hs0, w0);
            do_read(1, 32'hbffc, 0, hs1, w1);
        join
        chk("tie2_m0_first", 64'(w0), 64'd0);
        chk("tie2_m1_after", 64'(hs1), 64'(hs0 + 4));

        do_read(0, 32'hbff8, 0, hs0, w0);

        // Write from m1 and read from m0 in the same cycle
        fork
            do_write(1, 32'h4000, 32'h00000100, 4'hF, 0, hs1, w1);
            do_read(0, 32'h0, 0, hs0, w0);
        join
        chk("concurrent_hs", 64'(hs1), 64'(hs0));
        do_read(1, 32'h4000, 0, hs0, w0);
        chk("readback_direct", 64'(m1_axi_rdata), 64'h100);

        do_read(0, 32'h1234, 0, hs0, w0);
        do_read(0, 32'h4000, 0, hs0, w0);

        // m0 stalls rready for 5 cycles while m1 waits
        fork
            do_read(0, 32'h4004, 5, hs0, w0);
            begin @(posedge clk); #1; do_read(1, 32'h0, 0, hs1, w1); end
        join
        chk("stall_m1_after", 64'(hs1), 64'(hs0 + 3 + 5 + 1));

        // Reset while the write FSM waits for B
        set_aw(0, 32'h4004, 32'hdeadbeef, 4'hF, 1'b1);
        #1;
        chk("rst_wr_grant", 64'(m0_axi_awready), 64'd1);
        @(posedge clk); #1;
        set_aw(0, 32'h4004, 32'hdeadbeef, 4'hF, 1'b0);
        @(posedge clk); #1;
        chk("rst_wr_in_resp", 64'(s_axi_bready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_mid_m_valids", 64'({m0_axi_bvalid, m1_axi_bvalid, m0_axi_rvalid, m1_axi_rvalid}), 64'd0);
        chk("rst_mid_s", 64'({s_axi_bready, s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_rready}), 64'd0);
        do_write(0, 32'h4004, 32'h12345678, 4'hF, 0, hs0, w0);
        chk("rst_fresh_wr_rearm", 64'(w0), 64'd0);
        do_read(0, 32'h4004, 0, hs0, w0);
        do_read(1, 32'h4000, 0, hs0, w0);

        // Random sequential traffic; each channel must accept with no wait
        for (int k = 0; k < 24; k++) begin
            rm = int'($urandom_range(0, 1));
            ra = addrs[$urandom_range(0, 6)];
            rhold = int'($urandom_range(0, 2));
            rsel = int'($urandom_range(0, 1));
            rd = $urandom;
            rs = 4'($urandom_range(1, 15));
            if (rsel == 1) do_write(rm, ra, rd, rs, rhold, hs0, w0);
            else           do_read(rm, ra, rhold, hs0, w0);
            chk("rand_rearm", 64'(w0), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clint_axil_arbiter.md
# clint_axil_arbiter

Two-master AXI4-Lite arbiter in front of the CLINT slave port. It shares the timer/software-interrupt register block between master 0 (core data port) and master 1 (debug/loader port). Read and write channels are arbitrated independently, each round-robin with one outstanding transaction. Slave responses, including SLVERR for unmapped offsets, are forwarded unchanged to the owning master.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports. N = 0,1 denotes one port per master; a/b/c lists widths in name order.
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- mN_axi_araddr/arprot/arvalid  in  ADDR_W/3/1  AR from master N
- mN_axi_arready  out  1  AR accept to master N
- mN_axi_rdata/rresp/rvalid  out  DATA_W/2/1  R to master N
- mN_axi_rready  in  1  R accept from master N
- mN_axi_awaddr/awprot/awvalid  in  ADDR_W/3/1  AW from master N
- mN_axi_wdata/wstrb/wvalid  in  DATA_W/DATA_W/8/1  W from master N
- mN_axi_awready/wready  out  1/1  AW/W accept to master N
- mN_axi_bresp/bvalid  out  2/1  B to master N
- mN_axi_bready  in  1  B accept from master N
- s_axi_araddr/arprot/arvalid  out  ADDR_W/3/1  AR to CLINT
- s_axi_arready  in  1  AR accept from CLINT
- s_axi_rdata/rresp/rvalid  in  DATA_W/2/1  R from CLINT
- s_axi_rready  out  1  R accept to CLINT
- s_axi_awaddr/awprot/awvalid, s_axi_wdata/wstrb/wvalid  out  ADDR_W/3/1, DATA_W/DATA_W/8/1  AW/W to CLINT
- s_axi_awready/wready  in  1/1  AW/W accept from CLINT
- s_axi_bresp/bvalid  in  2/1  B from CLINT
- s_axi_bready  out  1  B accept to CLINT

## Operation
- Each channel runs its own FSM: IDLE → ADDR → RESP → DONE → IDLE.
- IDLE:
  - Read request = mN_arvalid. Write request = mN_awvalid && mN_wvalid; AW and W must be presented together, because the CLINT only acts on simultaneous awvalid/wvalid.
  - Grant goes to the single requester. With two requesters, grant goes to master ≠ last-served.
  - mN_arready (read) or mN_awready = mN_wready (write) is driven combinationally high for the granted master only.
  - On the handshake edge: latch addr/prot (and data/strb), record the owner, go to ADDR.
- ADDR:
  - Read: s_arvalid = 1 until s_arready; then RESP.
  - Write: s_awvalid and s_wvalid are asserted together. Each drops independently once its own ready is seen. Go to RESP when both have been accepted.
- RESP:
  - s_rready (or s_bready) = 1.
  - On s_rvalid (or s_bvalid): latch rdata/rresp (or bresp), go to DONE.
- DONE:
  - Owner's mN_rvalid (or mN_bvalid) = 1 with latched payload; the other master sees valid = 0.
  - On the owner's ready: update last-served to the owner, go to IDLE.
- Non-owner masters receive arready/awready/wready = 0 throughout a transaction.
- Read and write FSMs are fully concurrent; a read and a write may both be at the slave in the same cycle.
- Resp codes pass through: 00 OKAY, 10 SLVERR. The arbiter never generates responses itself.
- Reset:
  - All s_*valid, s_*ready, mN_*valid = 0. Payload registers = 0. FSMs = IDLE. last-served = master 1, so master 0 wins the first tie.
  - Reset mid-transaction abandons the transaction. The CLINT is reset by the same reset (inverted), so no stale response survives.

## Timing
- All outputs except mN_arready/awready/wready are registered.
- Read latency with the CLINT (always-ready, 1-cycle registered response), counted from the master AR handshake edge as cycle 0:
  - s_arvalid in cycle 1.
  - CLINT rvalid in cycle 2.
  - mN_rvalid in cycle 3.
- Write latency has the same shape: mN_bvalid in cycle 3.
- Channel re-arms in the cycle after the DONE handshake. Back-to-back throughput is one transaction per 4 cycles per channel.
- The slave handshake is stalled indefinitely if s_*ready / s_*valid never arrive. There is no timeout.
- A master dropping valid before its ready is a protocol violation; behaviour is undefined.

## Structure
- Package clint_bus_pkg:
  - chan_state_t enum {IDLE, ADDR, RESP, DONE}
  - localparams RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - ADDR_W/DATA_W defaults
- Sub-module rr_arb2: 2-way round-robin grant from req[1:0] and last-served bit. Instantiated once for read and once for write.
- Read and write FSMs live in the top module.

## Test plan
- Single read, m0 araddr 0xbff8 → s_araddr 0xbff8 in cycle 1; m0_rvalid in cycle 3 carrying the CLINT mtime[31:0], rresp 00; m1 sees no valid.
- Simultaneous m0/m1 reads from reset → m0 served first, m1's arready held 0 until m0's R handshake, then m1 served. Next tie after that goes to m0.
- m1 writes 0x4000 data 0x00000100 wstrb 0xF while m0 reads 0x0 in the same cycle → both complete in cycle 3; a later read of 0x4000 returns 0x00000100.
- m0 read of unmapped 0x1234 → m0_rresp = 10 forwarded unchanged; next transaction unaffected.
- m0 holds rready = 0 for 5 cycles in DONE → rvalid and rdata stable; m1 request not granted until the handshake.
- rst asserted while the write FSM is in RESP → all valids 0 next cycle, FSM IDLE; a fresh m0 write then completes normally.
